display_driver_bcm: RTL and testbench

DISPLAY_DRIVER_BCM -- requirements
Module: display_driver_bcm

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_shifter.sv | 118 +++++++++++
 rtl/display_driver_bcm.sv | 149 ++++++++++++++
 tb/tb_display_driver_bcm.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types for the BCM panel driver: shift/display FSM state encodings,
// oe/lat polarity constants and a width helper.
package display_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } shift_state_t;

   typedef enum logic [2:0] {
      D_IDLE,
      D_BLANK,
      D_LATCH,
      D_SETTLE,
      D_ON
   } disp_state_t;

   localparam logic OE_ACTIVE    = 1'b1;
   localparam logic OE_INACTIVE  = 1'b0;
   localparam logic LAT_ACTIVE   = 1'b1;
   localparam logic LAT_INACTIVE = 1'b0;

   // Address width that stays legal for a dimension of one.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_shifter.sv
// Shift FSM: fetches one row/plane of pixels from the frame buffer and shifts
// it out serially on rgb/oclk, one column every two clocks.
module display_shifter
   import display_pkg::*;
#(
   parameter int segments      = 1,
   parameter int rows          = 8,
   parameter int columns       = 32,
   parameter int bitwidth      = 8,
   parameter int pixel_latency = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                ack,
   input  logic [bitwidth*3*segments-1:0]      pixel,
   output logic [clog2_min1(rows)-1:0]         addr_row,
   output logic [clog2_min1(columns)-1:0]      addr_col,
   output logic [clog2_min1(bitwidth)-1:0]     plane,
   output logic [3*segments-1:0]               rgb,
   output logic                                oclk,
   output logic                                done
);

   localparam int row_w   = clog2_min1(rows);
   localparam int col_w   = clog2_min1(columns);
   localparam int plane_w = clog2_min1(bitwidth);
   localparam int cnt_w   = $clog2(columns + 1);

   shift_state_t               state, state_n;
   logic [cnt_w-1:0]           issued, loaded;
   logic                       phase, issue, rise_pend;
   logic [pixel_latency-1:0]   pipe;
   logic [3*segments-1:0]      rgb_n;
   logic                       last_plane, last_row, load, shift_done;

   assign last_plane = (plane == plane_w'(bitwidth - 1));
   assign last_row   = (addr_row == row_w'(rows - 1));
   assign load       = pipe[pixel_latency-1];
   assign shift_done = rise_pend && (loaded == cnt_w'(columns));
   assign done       = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_SHIFT;
         S_SHIFT: if (shift_done) state_n = S_DONE;
         S_DONE:  if (ack) state_n = (last_plane && last_row) ? S_IDLE : S_SHIFT;
         default: state_n = S_IDLE;
      endcase
   end

   // Channel c of segment i sits at pixel[(3*i+c)*bitwidth +: bitwidth], c=0 is red.
   always_comb begin
      rgb_n = '0;
      for (int i = 0; i < segments; i++)
         for (int c = 0; c < 3; c++)
            rgb_n[3*i+c] = pixel[(3*i+c)*bitwidth + int'(plane)];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_row  <= '0;
         addr_col  <= '0;
         plane     <= '0;
         rgb       <= '0;
         oclk      <= 1'b0;
         issued    <= '0;
         loaded    <= '0;
         phase     <= 1'b0;
         issue     <= 1'b0;
         rise_pend <= 1'b0;
         pipe      <= '0;
      end else begin
         pipe[0] <= issue;
         for (int k = 1; k < pixel_latency; k++) pipe[k] <= pipe[k-1];
         rise_pend <= load;
         issue     <= 1'b0;
         if (state == S_SHIFT) begin
            phase <= ~phase;
            if (!phase && issued != cnt_w'(columns)) begin
               issue    <= 1'b1;
               addr_col <= col_w'(issued);
               issued   <= issued + cnt_w'(1);
            end
         end else begin
            phase  <= 1'b0;
            issued <= '0;
            loaded <= '0;
         end
         // Pixel is valid pixel_latency cycles after its address; capture it
         // one cycle later together with the falling oclk.
         if (load) begin
            rgb    <= rgb_n;
            oclk   <= 1'b0;
            loaded <= loaded + cnt_w'(1);
         end
         if (rise_pend) oclk <= 1'b1;
         if (state == S_DONE && ack) begin
            if (last_plane) begin
               plane    <= '0;
               addr_row <= last_row ? '0 : addr_row + row_w'(1);
            end else begin
               plane <= plane + plane_w'(1);
            end
         end
      end
   end

endmodule

// File: rtl/display_driver_bcm.sv
// BCM LED-panel driver top: display FSM (blank/latch/settle/on) around the
// shifter. Define DISPLAY_BRIGHTNESS_EN to add a global brightness input.
module display_driver_bcm
   import display_pkg::*;
#(
   parameter int segments      = 1,
   parameter int rows          = 8,
   parameter int columns       = 32,
   parameter int bitwidth      = 8,
   parameter int base_ticks    = 4,
   parameter int pixel_latency = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
`ifdef DISPLAY_BRIGHTNESS_EN
   input  logic [7:0]                          brightness,
`endif
   output logic [clog2_min1(rows)-1:0]         addr_row,
   output logic [clog2_min1(columns)-1:0]      addr_col,
   input  logic [bitwidth*3*segments-1:0]      pixel,
   output logic [3*segments-1:0]               rgb,
   output logic                                oclk,
   output logic                                lat,
   output logic                                oe,
   output logic [clog2_min1(rows)-1:0]         row,
   output logic                                frame_complete
);

   localparam int row_w   = clog2_min1(rows);
   localparam int plane_w = clog2_min1(bitwidth);
   localparam int on_w    = $clog2((base_ticks << (bitwidth - 1)) + 1);

   disp_state_t           state, state_n;
   logic [plane_w-1:0]    lat_plane, sh_plane;
   logic [row_w-1:0]      sh_row;
   logic [on_w-1:0]       on_cnt, on_cnt_n, on_lim, dur;
   logic                  start, ack, sh_done, frame_last;
   logic                  oe_n, lat_n, fc_n;

   function automatic logic [on_w-1:0] ticks(input logic [plane_w-1:0] p);
      return on_w'(base_ticks) << p;
   endfunction

   assign dur        = ticks(lat_plane);
   assign frame_last = (row == row_w'(rows - 1)) && (lat_plane == plane_w'(bitwidth - 1));
   assign addr_row   = sh_row;

   display_shifter #(
      .segments      (segments),
      .rows          (rows),
      .columns       (columns),
      .bitwidth      (bitwidth),
      .pixel_latency (pixel_latency)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ack      (ack),
      .pixel    (pixel),
      .addr_row (sh_row),
      .addr_col (addr_col),
      .plane    (sh_plane),
      .rgb      (rgb),
      .oclk     (oclk),
      .done     (sh_done)
   );

`ifdef DISPLAY_BRIGHTNESS_EN
   localparam int prod_w = on_w + 8;
   always_ff @(posedge clk) begin
      if (rst)                   on_lim <= '0;
      else if (state == D_LATCH) on_lim <= on_w'((prod_w'(dur) * prod_w'(brightness)) >> 8);
   end
`else
   assign on_lim = dur;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= D_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      on_cnt_n = on_cnt;
      start    = 1'b0;
      ack      = 1'b0;
      fc_n     = 1'b0;
      unique case (state)
         D_IDLE: if (en) begin
            state_n = D_BLANK;
            start   = 1'b1;
         end
         D_BLANK: if (sh_done) begin
            state_n = D_LATCH;
            ack     = 1'b1;
         end
         D_LATCH: state_n = D_SETTLE;
         D_SETTLE: begin
            state_n  = D_ON;
            on_cnt_n = '0;
         end
         D_ON: begin
            if (on_cnt == dur - on_w'(1)) begin
               if (frame_last) begin
                  // Frame boundary: the only place en is honoured mid-run.
                  fc_n = 1'b1;
                  if (en) begin
                     state_n = D_BLANK;
                     start   = 1'b1;
                  end else begin
                     state_n = D_IDLE;
                  end
               end else begin
                  state_n = D_BLANK;
               end
            end else begin
               on_cnt_n = on_cnt + on_w'(1);
            end
         end
         default: state_n = D_IDLE;
      endcase
      oe_n  = (state_n == D_ON && on_cnt_n < on_lim) ? OE_ACTIVE : OE_INACTIVE;
      lat_n = (state_n == D_LATCH) ? LAT_ACTIVE : LAT_INACTIVE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         on_cnt         <= '0;
         lat_plane      <= '0;
         row            <= '0;
         oe             <= OE_INACTIVE;
         lat            <= LAT_INACTIVE;
         frame_complete <= 1'b0;
      end else begin
         on_cnt         <= on_cnt_n;
         oe             <= oe_n;
         lat            <= lat_n;
         frame_complete <= fc_n;
         // Row only moves entering D_LATCH, where oe is already low.
         if (ack) begin
            row       <= sh_row;
            lat_plane <= sh_plane;
         end
      end
   end

endmodule

// File: tb/tb_display_driver_bcm.sv
// Directed bench for display_driver_bcm: rows=2, columns=4, bitwidth=2,
// base_ticks=4; a negedge monitor records latches, oe runs and oclk edges.
module tb_display_driver_bcm;

   localparam int ROWS = 2, COLS = 4, BW = 2, BASE = 4, LATN = 2, SEG = 1;

   logic             clk = 1'b0;
   logic             rst, en;
   logic [5:0]       pixel;
   logic [0:0]       addr_row, row;
   logic [1:0]       addr_col;
   logic [2:0]       rgb;
   logic             oclk, lat, oe, frame_complete;
`ifdef DISPLAY_BRIGHTNESS_EN
   logic [7:0]       brightness;
`endif

   int total = 0;
   int bad   = 0;
   int mode  = 0;

   display_driver_bcm #(
      .segments(SEG), .rows(ROWS), .columns(COLS), .bitwidth(BW),
      .base_ticks(BASE), .pixel_latency(LATN)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
`ifdef DISPLAY_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .addr_row(addr_row), .addr_col(addr_col), .pixel(pixel), .rgb(rgb),
      .oclk(oclk), .lat(lat), .oe(oe), .row(row), .frame_complete(frame_complete)
   );

   always #5 clk = ~clk;

   // Frame buffer model with a two-cycle read latency.
   logic [2:0] a1 = '0, a2 = '0;
   always @(posedge clk) begin
      a1 <= {addr_row, addr_col};
      a2 <= a1;
   end

   function automatic logic [5:0] pix_of(input int m, input logic r, input logic [1:0] c);
      if (m == 0) return 6'b00_00_10;
      return {~c, {1'b0, r}, c};
   endfunction

   assign pixel = pix_of(mode, a2[2], a2[1:0]);

   function automatic logic [2:0] exp_rgb(input int m, input int r, input int p, input int c);
      logic [1:0] cc;
      logic       rr;
      cc = c[1:0];
      rr = r[0];
      if (m == 0) return (p == 1) ? 3'b001 : 3'b000;
      return {~cc[p], (p == 0) ? rr : 1'b0, cc[p]};
   endfunction

   function automatic int exp_on(input int p);
      int d;
      d = BASE << p;
`ifdef DISPLAY_BRIGHTNESS_EN
      d = (d * int'(brightness)) >> 8;
`endif
      return d;
   endfunction

   // Monitor: sampled at negedge, only this process writes these.
   int         lat_rows[$];
   int         oe_runs[$];
   logic [2:0] rises[$];
   int         oe_run = 0, fc_cnt = 0, tog_cnt = 0, oe_hi_cnt = 0, viol = 0;
   logic       prev_oe = 1'b0, prev_oclk = 1'b0;
   logic [0:0] prev_row = '0;

   always @(negedge clk) begin
      if (oe && lat) viol++;
      if (oe && row != prev_row) viol++;
      if (lat) lat_rows.push_back(int'(row));
      if (oe) begin
         oe_run++;
         oe_hi_cnt++;
      end else if (prev_oe) begin
         oe_runs.push_back(oe_run);
         oe_run = 0;
      end
      if (oclk && !prev_oclk) rises.push_back(rgb);
      if (oclk != prev_oclk) tog_cnt++;
      if (frame_complete) fc_cnt++;
      prev_oe   = oe;
      prev_oclk = oclk;
      prev_row  = row;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fc(input int budget, input string name);
      int n = 0;
      while (!frame_complete && n < budget) begin
         tick();
         n++;
      end
      if (!frame_complete) begin
         total++; bad++;
         $display("FAIL %s: frame_complete not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe); end
      total++; if (lat !== 1'b0) begin bad++; $display("FAIL reset_lat: got %b want 0", lat); end
      total++; if (oclk !== 1'b0) begin bad++; $display("FAIL reset_oclk: got %b want 0", oclk); end
      total++; if (rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb: got %b want 000", rgb); end
      total++; if (row !== 1'b0) begin bad++; $display("FAIL reset_row: got %b want 0", row); end
      total++; if ({addr_row, addr_col} !== 3'b000)
         begin bad++; $display("FAIL reset_addr: got %b want 000", {addr_row, addr_col}); end
      total++; if (frame_complete !== 1'b0)
         begin bad++; $display("FAIL reset_fc: got %b want 0", frame_complete); end
      rst = 1'b0;
      begin
         int t0, o0;
         t0 = tog_cnt;
         o0 = oe_hi_cnt;
         repeat (20) tick();
         total++; if (tog_cnt != t0 || oe_hi_cnt != o0) begin
            bad++; $display("FAIL idle_en_low: oclk toggles %0d oe cycles %0d want 0 0",
                            tog_cnt - t0, oe_hi_cnt - o0);
         end
      end
   endtask

   task automatic test_plane_frame();
      int lb, ob, rb, fb;
      lb = lat_rows.size(); ob = oe_runs.size(); rb = rises.size(); fb = fc_cnt;
      mode = 0;
      en   = 1'b1;
      wait_fc(400, "frame0");
      total++; if (lat_rows.size() - lb != 4) begin
         bad++; $display("FAIL lat_count: got %0d want 4", lat_rows.size() - lb);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++; if (lat_rows[lb+k] != k / 2) begin
               bad++; $display("FAIL lat_row[%0d]: got %0d want %0d", k, lat_rows[lb+k], k / 2);
            end
         end
      end
      total++; if (oe_runs.size() - ob != 4) begin
         bad++; $display("FAIL oe_run_count: got %0d want 4", oe_runs.size() - ob);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++; if (oe_runs[ob+k] != exp_on(k % 2)) begin
               bad++; $display("FAIL oe_run[%0d]: got %0d want %0d", k, oe_runs[ob+k], exp_on(k % 2));
            end
         end
      end
      total++; if (rises.size() - rb != 16) begin
         bad++; $display("FAIL oclk_edges: got %0d want 16", rises.size() - rb);
      end else begin
         for (int k = 0; k < 16; k++) begin
            total++; if (rises[rb+k] !== exp_rgb(0, k / 8, (k / 4) % 2, k % 4)) begin
               bad++; $display("FAIL rgb_red[%0d]: got %b want %b", k, rises[rb+k],
                               exp_rgb(0, k / 8, (k / 4) % 2, k % 4));
            end
         end
      end
      total++; if (fc_cnt - fb != 1) begin
         bad++; $display("FAIL fc_count: got %0d want 1", fc_cnt - fb);
      end
      tick();
      total++; if (frame_complete !== 1'b0) begin
         bad++; $display("FAIL fc_width: got %b want 0 one cycle later", frame_complete);
      end
   endtask

   task automatic test_en_drop();
      int t0, o0, l0, lb, rb;
      repeat (20) tick();
      en = 1'b0;
      wait_fc(400, "en_drop_frame");
      tick();
      t0 = tog_cnt; o0 = oe_hi_cnt; l0 = lat_rows.size();
      repeat (60) tick();
      total++; if (tog_cnt != t0 || oe_hi_cnt != o0 || lat_rows.size() != l0) begin
         bad++; $display("FAIL stopped: oclk toggles %0d oe cycles %0d lats %0d want 0 0 0",
                         tog_cnt - t0, oe_hi_cnt - o0, lat_rows.size() - l0);
      end
      mode = 1;
      lb = lat_rows.size(); rb = rises.size();
      en = 1'b1;
      repeat (3) tick();
      en = 1'b0;
      wait_fc(400, "restart_frame");
      total++; if (lat_rows.size() - lb != 4) begin
         bad++; $display("FAIL restart_lat_count: got %0d want 4", lat_rows.size() - lb);
      end else begin
         total++; if (lat_rows[lb] != 0 || lat_rows[lb+1] != 0 || lat_rows[lb+2] != 1 || lat_rows[lb+3] != 1) begin
            bad++; $display("FAIL restart_rows: got %0d%0d%0d%0d want 0011",
                            lat_rows[lb], lat_rows[lb+1], lat_rows[lb+2], lat_rows[lb+3]);
         end
      end
      total++; if (rises.size() - rb != 16) begin
         bad++; $display("FAIL restart_edges: got %0d want 16", rises.size() - rb);
      end else begin
         for (int k = 0; k < 16; k++) begin
            total++; if (rises[rb+k] !== exp_rgb(1, k / 8, (k / 4) % 2, k % 4)) begin
               bad++; $display("FAIL rgb_pattern[%0d]: got %b want %b", k, rises[rb+k],
                               exp_rgb(1, k / 8, (k / 4) % 2, k % 4));
            end
         end
      end
   endtask

   task automatic test_rst_mid_on();
      int lb, ob, rb, n;
      mode = 1;
      lb = lat_rows.size();
      en = 1'b1;
      n  = 0;
      while (!(lat_rows.size() - lb >= 2 && oe) && n < 400) begin
         tick();
         n++;
      end
      total++; if (!(lat_rows.size() - lb >= 2 && oe)) begin
         bad++; $display("FAIL rst_wait: plane 1 on-time not reached, lats %0d", lat_rows.size() - lb);
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      total++; if (oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", oe); end
      total++; if ({lat, oclk, rgb, row, addr_row, addr_col, frame_complete} !== 10'd0) begin
         bad++; $display("FAIL rst_outputs: got %b want all 0",
                         {lat, oclk, rgb, row, addr_row, addr_col, frame_complete});
      end
      tick();
      lb = lat_rows.size(); ob = oe_runs.size(); rb = rises.size();
      rst = 1'b0;
      repeat (2) tick();
      en = 1'b0;
      wait_fc(400, "rst_restart_frame");
      total++; if (lat_rows.size() - lb != 4 || oe_runs.size() - ob != 4) begin
         bad++; $display("FAIL rst_restart_count: lats %0d runs %0d want 4 4",
                         lat_rows.size() - lb, oe_runs.size() - ob);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++; if (lat_rows[lb+k] != k / 2 || oe_runs[ob+k] != exp_on(k % 2)) begin
               bad++; $display("FAIL rst_restart[%0d]: row %0d run %0d want %0d %0d", k,
                               lat_rows[lb+k], oe_runs[ob+k], k / 2, exp_on(k % 2));
            end
         end
      end
      total++; if (rises.size() - rb < 4) begin
         bad++; $display("FAIL rst_restart_edges: got %0d want >=4", rises.size() - rb);
      end else begin
         total++; if (rises[rb] !== 3'b100 || rises[rb+1] !== 3'b001 ||
                      rises[rb+2] !== 3'b100 || rises[rb+3] !== 3'b001) begin
            bad++; $display("FAIL rst_restart_plane0: got %b %b %b %b want 100 001 100 001",
                            rises[rb], rises[rb+1], rises[rb+2], rises[rb+3]);
         end
      end
   endtask

`ifdef DISPLAY_BRIGHTNESS_EN
   task automatic test_brightness();
      int ob, o0, fb;
      brightness = 8'd128;
      ob = oe_runs.size();
      en = 1'b1;
      repeat (3) tick();
      en = 1'b0;
      wait_fc(400, "bright128_frame");
      total++; if (oe_runs.size() - ob != 4) begin
         bad++; $display("FAIL bright128_count: got %0d want 4", oe_runs.size() - ob);
      end else begin
         total++; if (oe_runs[ob] != 2 || oe_runs[ob+1] != 4 || oe_runs[ob+2] != 2 || oe_runs[ob+3] != 4) begin
            bad++; $display("FAIL bright128_runs: got %0d %0d %0d %0d want 2 4 2 4",
                            oe_runs[ob], oe_runs[ob+1], oe_runs[ob+2], oe_runs[ob+3]);
         end
      end
      repeat (4) tick();
      brightness = 8'd0;
      o0 = oe_hi_cnt; fb = fc_cnt;
      en = 1'b1;
      repeat (3) tick();
      en = 1'b0;
      wait_fc(400, "bright0_frame");
      total++; if (oe_hi_cnt != o0 || fc_cnt - fb != 1) begin
         bad++; $display("FAIL bright0: oe cycles %0d frames %0d want 0 1", oe_hi_cnt - o0, fc_cnt - fb);
      end
      brightness = 8'd255;
   endtask
`endif

   task automatic test_invariants();
      total++; if (viol != 0) begin
         bad++; $display("FAIL invariants: %0d cycles with oe&&lat or row change under oe, want 0", viol);
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
`ifdef DISPLAY_BRIGHTNESS_EN
      brightness = 8'd255;
`endif
      test_reset();
      test_plane_frame();
      test_en_drop();
      test_rst_mid_on();
`ifdef DISPLAY_BRIGHTNESS_EN
      test_brightness();
`endif
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
